// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } clr_state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - background clear sequencer walking every entry once
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_ptr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] ptr_next;

    // State and pointer registers; reset abandons any walk without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLR_IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= ptr_next;
        end
    end

    // Next state, pointer advance and status outputs
    always_comb begin
        state_next = state;
        ptr_next   = clr_ptr;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        clr_en     = 1'b0;
        case (state)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_next = CLR_CLEAR;
                    ptr_next   = '0;
                end
            end
            CLR_CLEAR: begin
                clr_busy = 1'b1;
                clr_en   = 1'b1;
                ptr_next = clr_ptr + 1'b1;
                if (clr_ptr == LAST_PTR) begin
                    state_next = CLR_DONE;
                end
            end
            CLR_DONE: begin
                clr_done   = 1'b1;
                state_next = CLR_IDLE;
            end
            default: begin
                state_next = CLR_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with bypass and clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wen,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done,
    output logic                    wr_drop
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_ptr;
    logic              wr_ok;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_en   (clr_en),
        .clr_ptr  (clr_ptr)
    );

    // Writes are refused while clearing and, with a hardwired zero, to entry 0
    assign wr_ok   = wen && !clr_busy && !((ZERO_REG != 0) && (waddr == '0));
    assign wr_drop = wen && clr_busy;

    // Storage: async reset wipes everything, the clear walk beats the write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_ptr] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];
        assign rdata[k*DATA_W +: DATA_W] = rd;

        // Read mux: zero entry, then clear blanking, then same-cycle bypass, then storage
        always_comb begin
            rd = mem[ra];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if (clr_busy) begin
                rd = '0;
            end else if ((BYPASS != 0) && wen && (ra == waddr)) begin
                rd = wdata;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp in default and plain configurations
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic        clr_req = 1'b0;

    logic [63:0] rdata_a, rdata_b;
    logic        busy_a, done_a, drop_a;
    logic        busy_b, done_b, drop_b;

    int checks   = 0;
    int failures = 0;

    string       q_name [$];
    int          q_sel  [$];
    logic [31:0] q_exp  [$];

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_a), .clr_req(clr_req),
        .clr_busy(busy_a), .clr_done(done_a), .wr_drop(drop_a)
    );

    regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .clr_req(clr_req),
        .clr_busy(busy_b), .clr_done(done_b), .wr_drop(drop_b)
    );

    localparam int A0 = 0, A1 = 1, B0 = 2, B1 = 3, BUSY = 4, DONE = 5, DROP = 6;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            A0:      return rdata_a[31:0];
            A1:      return rdata_a[63:32];
            B0:      return rdata_b[31:0];
            B1:      return rdata_b[63:32];
            BUSY:    return {31'b0, busy_a};
            DONE:    return {31'b0, done_a};
            DROP:    return {30'b0, drop_b, drop_a};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string nm, input int sel, input logic [31:0] v);
        q_name.push_back(nm);
        q_sel.push_back(sel);
        q_exp.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    // Monitor: drains the scoreboard mid-cycle, away from the active edge
    always @(negedge clk) begin
        while (q_sel.size() > 0) begin
            string       nm;
            int          sel;
            logic [31:0] ex, act;
            nm  = q_name.pop_front();
            sel = q_sel.pop_front();
            ex  = q_exp.pop_front();
            act = observe(sel);
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL %s actual=%h required=%h at %0t", nm, act, ex, $time);
            end
        end
    end

    initial begin
        step();
        step();
        rst = 1'b0;

        // Post-reset: every address reads zero on every port of both configurations
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            expect_val($sformatf("rst_a0_%0d", a), A0, 32'h0);
            expect_val($sformatf("rst_a1_%0d", a), A1, 32'h0);
            expect_val($sformatf("rst_b0_%0d", a), B0, 32'h0);
            expect_val($sformatf("rst_b1_%0d", a), B1, 32'h0);
            if (a == 0) begin
                expect_val("rst_busy", BUSY, 32'h0);
                expect_val("rst_done", DONE, 32'h0);
                expect_val("rst_drop", DROP, 32'h0);
            end
            step();
        end

        // Plain write then read back next cycle
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        set_rd(5'd1, 5'd2);
        step();
        wen = 1'b0;
        set_rd(5'd5, 5'd6);
        expect_val("wr5_a0", A0, 32'hDEAD_BEEF);
        expect_val("wr5_a1", A1, 32'h0);
        expect_val("wr5_b0", B0, 32'hDEAD_BEEF);
        expect_val("wr5_b1", B1, 32'h0);
        step();

        // Same-cycle bypass versus registered visibility
        wen = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        set_rd(5'd5, 5'd7);
        expect_val("byp_a1", A1, 32'h1234_5678);
        expect_val("nobyp_b1_old", B1, 32'h0);
        expect_val("byp_a0_other", A0, 32'hDEAD_BEEF);
        step();
        wen = 1'b0;
        expect_val("byp_a1_next", A1, 32'h1234_5678);
        expect_val("nobyp_b1_new", B1, 32'h1234_5678);
        step();

        // Write to entry 0: hardwired zero versus ordinary register
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        set_rd(5'd0, 5'd0);
        expect_val("r0_a0_same", A0, 32'h0);
        expect_val("r0_b0_same", B0, 32'h0);
        step();
        wen = 1'b0;
        expect_val("r0_a0_next", A0, 32'h0);
        expect_val("r0_a1_next", A1, 32'h0);
        expect_val("r0_b0_next", B0, 32'hFFFF_FFFF);
        step();

        // Writing zero over a live value stores zero
        wen = 1'b1; waddr = 5'd7; wdata = 32'h0;
        step();
        wen = 1'b0;
        set_rd(5'd7, 5'd5);
        expect_val("wr0_a0", A0, 32'h0);
        expect_val("wr0_a1", A1, 32'hDEAD_BEEF);
        step();

        // Background clear: 32 busy cycles, dropped write, done pulse after
        wen = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
        step();
        wen = 1'b0;
        clr_req = 1'b1;
        set_rd(5'd3, 5'd9);
        expect_val("pre_clr_r3", A0, 32'hA5A5_A5A5);
        expect_val("pre_clr_busy", BUSY, 32'h0);
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wen = (i == 5);
            waddr = 5'd9; wdata = 32'h0000_0999;
            expect_val($sformatf("clr_busy_%0d", i), BUSY, 32'h1);
            expect_val($sformatf("clr_done_%0d", i), DONE, 32'h0);
            expect_val($sformatf("clr_drop_%0d", i), DROP, (i == 5) ? 32'h3 : 32'h0);
            expect_val($sformatf("clr_rd_%0d", i), A0, 32'h0);
            step();
        end
        wen = 1'b0;
        expect_val("clr_end_busy", BUSY, 32'h0);
        expect_val("clr_end_done", DONE, 32'h1);
        step();
        expect_val("clr_after_done", DONE, 32'h0);
        expect_val("clr_r3_a", A0, 32'h0);
        expect_val("clr_r9_a", A1, 32'h0);
        expect_val("clr_r3_b", B0, 32'h0);
        expect_val("clr_r9_b", B1, 32'h0);
        step();
        set_rd(5'd5, 5'd0);
        expect_val("clr_r5_b", B0, 32'h0);
        expect_val("clr_r0_b", B1, 32'h0);
        step();

        // Reset in the middle of a clear walk
        wen = 1'b1; waddr = 5'd20; wdata = 32'h0BAD_F00D;
        step();
        wen = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_val($sformatf("rclr_busy_%0d", i), BUSY, 32'h1);
            step();
        end
        rst = 1'b1;
        expect_val("rst_mid_busy", BUSY, 32'h0);
        expect_val("rst_mid_done", DONE, 32'h0);
        step();
        rst = 1'b0;
        set_rd(5'd20, 5'd31);
        for (int i = 0; i < 3; i++) begin
            expect_val($sformatf("rst_mid_nodone_%0d", i), DONE, 32'h0);
            expect_val($sformatf("rst_mid_r20_%0d", i), A0, 32'h0);
            expect_val($sformatf("rst_mid_r20b_%0d", i), B0, 32'h0);
            step();
        end

        // Fresh clear after the interrupted one runs the full walk
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            expect_val($sformatf("re_busy_%0d", i), BUSY, 32'h1);
            expect_val($sformatf("re_done_%0d", i), DONE, 32'h0);
            step();
        end
        expect_val("re_end_busy", BUSY, 32'h0);
        expect_val("re_end_done", DONE, 32'h1);
        step();
        expect_val("re_idle_done", DONE, 32'h0);
        step();

        @(negedge clk);
        #1;
        checks++;
        if (q_sel.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q_sel.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
